// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer that sits on the common data bus.
package rob_pkg;

  localparam int WIDTH   = 31;               // MSB of data/address words
  localparam int ROB     = 2;                // MSB of ROB index
  localparam int CONTROL = 6;                // MSB of pcControl; bit 0 = redirect flag
  localparam int REG     = 4;                // MSB of architectural register index
  localparam int DEPTH   = 2 ** (ROB + 1);   // number of ROB entries

  // One ROB slot: bookkeeping bits plus the captured broadcast payload.
  typedef struct packed {
    logic               valid;
    logic               ready;
    logic [REG:0]       dest;
    logic [WIDTH:0]     result;
    logic               is_control;
    logic [WIDTH:0]     target_address;
    logic [CONTROL:0]   pc_control;
  } rob_entry_t;

  // Modular pointer increment; DEPTH is a power of two so the natural wrap suffices.
  function automatic logic [ROB:0] ptr_inc(input logic [ROB:0] ptr);
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/reorder_buffer_cdb.sv
// In-order reorder buffer on the consumer side of the common data bus.
// Allocates at dispatch, captures CDB broadcasts by ROB index, retires one
// completed entry per cycle in program order, raises redirect/flush when a
// redirecting control-flow entry retires, and serves two bypassed operand
// lookups to the rename stage.
module reorder_buffer_cdb
  import rob_pkg::*;
(
  input  logic               clk,
  input  logic               resetN,
  // common data bus (reorder-buffer view)
  input  logic [WIDTH:0]     dataBusResult,
  input  logic [ROB:0]       dataBusRobEntry,
  input  logic               dataBusValidBroadcast,
  input  logic [WIDTH:0]     dataBusTargetAddress,
  input  logic               dataBusIsControl,
  input  logic [CONTROL:0]   dataBusPcControl,
  // dispatch
  input  logic               allocReq,
  input  logic [REG:0]       allocDest,
  output logic [ROB:0]       allocEntry,
  output logic               robFull,
  // operand lookup
  input  logic [ROB:0]       srcRobA,
  input  logic [ROB:0]       srcRobB,
  output logic               readyA,
  output logic               readyB,
  output logic [WIDTH:0]     valueA,
  output logic [WIDTH:0]     valueB,
  // commit
  output logic               commitValid,
  output logic [REG:0]       commitDest,
  output logic [WIDTH:0]     commitResult,
  output logic [ROB:0]       commitRob,
  // redirect
  output logic               redirectValid,
  output logic [WIDTH:0]     redirectAddress,
  output logic               flush
);

  localparam logic [ROB+1:0] FULL_COUNT = (ROB+2)'(DEPTH);

  rob_entry_t       entry_q [DEPTH];
  rob_entry_t       entry_d [DEPTH];
  logic [ROB:0]     head_q, head_d;
  logic [ROB:0]     tail_q, tail_d;
  logic [ROB+1:0]   count_q, count_d;

  logic             commit_valid_q;
  logic [REG:0]     commit_dest_q;
  logic [WIDTH:0]   commit_result_q;
  logic [ROB:0]     commit_rob_q;
  logic             redirect_valid_q;
  logic [WIDTH:0]   redirect_address_q;
  logic             flush_q;

  logic             do_alloc;
  logic             do_writeback;
  logic             do_commit;
  logic             do_redirect;
  rob_entry_t       head_entry;

  // Decode this cycle's events; full/empty come from count only, never pointers.
  always_comb begin
    head_entry   = entry_q[head_q];
    robFull      = (count_q == FULL_COUNT);
    allocEntry   = tail_q;
    do_alloc     = allocReq && !robFull;
    do_writeback = dataBusValidBroadcast && entry_q[dataBusRobEntry].valid;
    do_commit    = head_entry.valid && head_entry.ready;
    do_redirect  = do_commit && head_entry.is_control && head_entry.pc_control[0];
  end

  // Next state for the entry array and pointers; a redirect overrides everything.
  // NOTE: every variable gets its default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // Writeback uses the registered valid bit, so a slot allocated this same
    // cycle cannot be hit by a broadcast.
    if (do_writeback) begin
      entry_d[dataBusRobEntry].ready      = 1'b1;
      entry_d[dataBusRobEntry].result     = dataBusResult;
      entry_d[dataBusRobEntry].is_control = dataBusIsControl;
      entry_d[dataBusRobEntry].pc_control = dataBusPcControl;
      if (dataBusIsControl) begin
        entry_d[dataBusRobEntry].target_address = dataBusTargetAddress;
      end
    end

    if (do_alloc) begin
      entry_d[tail_q]            = '0;
      entry_d[tail_q].valid      = 1'b1;
      entry_d[tail_q].dest       = allocDest;
      tail_d                     = ptr_inc(tail_q);
    end

    if (do_commit) begin
      entry_d[head_q].valid = 1'b0;
      head_d                = ptr_inc(head_q);
    end

    if (do_alloc && !do_commit) begin
      count_d = count_q + 1'b1;
    end else if (!do_alloc && do_commit) begin
      count_d = count_q - 1'b1;
    end

    // Retiring a taken redirect squashes every younger entry and any
    // allocation or writeback that arrived in the same cycle.
    if (do_redirect) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_d[i].valid = 1'b0;
        entry_d[i].ready = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Entry array and pointer registers.
  // NOTE: the whole entry array is reset, not just valid/ready, so stale
  // payload from before reset can never surface on an operand port.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Registered commit and redirect outputs; commit payload holds when idle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      commit_valid_q     <= 1'b0;
      commit_dest_q      <= '0;
      commit_result_q    <= '0;
      commit_rob_q       <= '0;
      redirect_valid_q   <= 1'b0;
      redirect_address_q <= '0;
      flush_q            <= 1'b0;
    end else begin
      commit_valid_q   <= do_commit;
      redirect_valid_q <= do_redirect;
      flush_q          <= do_redirect;
      if (do_commit) begin
        commit_dest_q   <= head_entry.dest;
        commit_result_q <= head_entry.result;
        commit_rob_q    <= head_q;
      end
      if (do_redirect) begin
        redirect_address_q <= head_entry.target_address;
      end
    end
  end

  // Operand lookup: live CDB result wins over storage for a valid entry.
  function automatic logic [WIDTH+1:0] lookup(input logic [ROB:0] src);
    rob_entry_t e;
    e = entry_q[src];
    if (dataBusValidBroadcast && (dataBusRobEntry == src) && e.valid) begin
      return {1'b1, dataBusResult};
    end else if (e.valid && e.ready) begin
      return {1'b1, e.result};
    end
    return '0;
  endfunction

  // Both rename-stage lookup ports.
  always_comb begin
    {readyA, valueA} = lookup(srcRobA);
    {readyB, valueB} = lookup(srcRobB);
  end

  assign commitValid     = commit_valid_q;
  assign commitDest      = commit_dest_q;
  assign commitResult    = commit_result_q;
  assign commitRob       = commit_rob_q;
  assign redirectValid   = redirect_valid_q;
  assign redirectAddress = redirect_address_q;
  assign flush           = flush_q;

endmodule
